// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: 2-flop synchronizer, per-bit debounce, sticky edge capture
// with write-1-to-clear, and a masked level interrupt. Zero-wait-state reads.
module pio_in_edge_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_MASK    = 2'd2,
    ADDR_CAPTURE = 2'd3
  } addr_e;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] edge_qual;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

  // Each bit's counter only advances while the synchronized input disagrees
  // with the filtered value; any agreement restarts the qualification window.
  always_comb begin
    sync1_d = in_port;
    s_d     = sync1_q;
    deb_d   = deb_q;
    edge_ev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i]   = s_q[i];
          edge_ev[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (EDGE_TYPE == 0)      edge_qual = edge_ev & s_q;
    else if (EDGE_TYPE == 1) edge_qual = edge_ev & ~s_q;
    else                     edge_qual = edge_ev;
  end

  // The clear is applied before the set so a coinciding edge keeps the bit.
  always_comb begin
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_en && (addr_e'(address) == ADDR_MASK))    mask_d = wdata;
    if (wr_en && (addr_e'(address) == ADDR_CAPTURE)) cap_d  = cap_q & ~wdata;
    cap_d = cap_d | edge_qual;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      s_q     <= '0;
      deb_q   <= '0;
      cnt_q   <= '{default: '0};
      mask_q  <= '0;
      cap_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (addr_e'(address))
      ADDR_DATA:    readdata = 32'(deb_q);
      ADDR_MASK:    readdata = 32'(mask_q);
      ADDR_CAPTURE: readdata = 32'(cap_q);
      default:      readdata = '0;
    endcase
  end

  assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: rising, falling and any-edge builds share one bus;
// expected values are queued when stimulus is applied and popped at sampling.
module tb_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in0, in1, in2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  always #5 clk = ~clk;

  pio_in_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0));

  pio_in_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1));

  pio_in_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2),
    .readdata(rd2), .irq(irq2));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int which, input bit want_irq);
    case (which)
      0:       return want_irq ? {31'b0, irq0} : rd0;
      1:       return want_irq ? {31'b0, irq1} : rd1;
      default: return want_irq ? {31'b0, irq2} : rd2;
    endcase
  endfunction

  task automatic expect_rd(input int which, input logic [1:0] a,
                           input logic [31:0] e, input string tag);
    exp_t it;
    sb.push_back('{tag, e});
    address = a;
    #1;
    it = sb.pop_front();
    check(it.tag, observe(which, 1'b0), it.exp);
  endtask

  task automatic expect_irq(input int which, input logic e, input string tag);
    exp_t it;
    sb.push_back('{tag, {31'b0, e}});
    #1;
    it = sb.pop_front();
    check(it.tag, observe(which, 1'b1), it.exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in0 = 4'h0; in1 = 4'hF; in2 = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    expect_rd(0, 2'd0, 32'h0, "reset_data");
    expect_rd(0, 2'd1, 32'h0, "reset_rsvd");
    expect_rd(0, 2'd2, 32'h0, "reset_mask");
    expect_rd(0, 2'd3, 32'h0, "reset_cap");
    expect_irq(0, 1'b0, "reset_irq_rise");
    expect_irq(1, 1'b0, "reset_irq_fall");
    expect_irq(2, 1'b0, "reset_irq_any");

    // three-cycle glitch on bit0 must be filtered out
    tick();
    in0 = 4'h1;
    repeat (3) tick();
    in0 = 4'h0;
    repeat (8) tick();
    expect_rd(0, 2'd0, 32'h0, "glitch_data");
    expect_rd(0, 2'd3, 32'h0, "glitch_cap");

    in0 = 4'h5;
    repeat (5) tick();
    expect_rd(0, 2'd0, 32'h0, "rise_early");
    tick();
    expect_rd(0, 2'd0, 32'h5, "rise_data");
    expect_rd(0, 2'd3, 32'h5, "rise_cap");
    expect_irq(0, 1'b0, "rise_irq_masked");

    bus_write(2'd0, 32'hF);
    expect_rd(0, 2'd0, 32'h5, "data_ro");
    bus_write(2'd1, 32'hF);
    expect_rd(0, 2'd1, 32'h0, "rsvd_ro");

    bus_write(2'd2, 32'hFFFF_FFF1);
    expect_rd(0, 2'd2, 32'h1, "mask_rd");
    expect_irq(0, 1'b1, "mask_irq");
    bus_write(2'd3, 32'h1);
    expect_rd(0, 2'd3, 32'h4, "clr_bit0");
    expect_irq(0, 1'b0, "clr_irq");
    bus_write(2'd3, 32'h0);
    expect_rd(0, 2'd3, 32'h4, "clr_zero");
    bus_write(2'd3, 32'h4);
    expect_rd(0, 2'd3, 32'h0, "clr_bit2");

    // clear of bit1 lands on the same edge that qualifies its rise
    bus_write(2'd2, 32'h2);
    in0 = 4'h7;
    repeat (5) tick();
    bus_write(2'd3, 32'h2);
    expect_rd(0, 2'd3, 32'h2, "collide_cap");
    expect_rd(0, 2'd0, 32'h7, "collide_data");
    expect_irq(0, 1'b1, "collide_irq");
    bus_write(2'd3, 32'h2);
    expect_rd(0, 2'd3, 32'h0, "collide_clr");
    expect_irq(0, 1'b0, "collide_irq_off");

    expect_rd(1, 2'd0, 32'hF, "fall_pre_data");
    expect_rd(1, 2'd3, 32'h0, "fall_no_rise_cap");
    in1 = 4'h0;
    repeat (5) tick();
    expect_rd(1, 2'd3, 32'h0, "fall_early");
    tick();
    expect_rd(1, 2'd3, 32'hF, "fall_cap");
    expect_rd(1, 2'd0, 32'h0, "fall_data");
    expect_irq(1, 1'b1, "fall_irq");

    in2 = 4'h8;
    repeat (6) tick();
    expect_rd(2, 2'd3, 32'h8, "any_rise_cap");
    bus_write(2'd3, 32'h8);
    expect_rd(2, 2'd3, 32'h0, "any_clr");
    in2 = 4'h0;
    repeat (6) tick();
    expect_rd(2, 2'd3, 32'h8, "any_fall_cap");
    expect_rd(2, 2'd0, 32'h0, "any_data");

    // reset mid-debounce, then the held input re-qualifies from scratch
    in0 = 4'hF;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_rd(0, 2'd0, 32'h0, "rst_mid_data");
    expect_rd(0, 2'd2, 32'h0, "rst_mid_mask");
    expect_rd(0, 2'd3, 32'h0, "rst_mid_cap");
    repeat (5) tick();
    expect_rd(0, 2'd0, 32'h0, "requal_early");
    tick();
    expect_rd(0, 2'd0, 32'hF, "requal_data");
    expect_rd(0, 2'd3, 32'hF, "requal_cap");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
